// File: rtl/pingpong_pkg.sv
// Shared types and constants for the ping-pong buffer scheduler.
package pingpong_pkg;

  // Top-level run sequencing.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } top_state_e;

  // Per-child launch state.
  typedef enum logic {
    X_IDLE = 1'b0,
    X_BUSY = 1'b1
  } side_state_e;

  localparam int NUM_BANKS = 2;

endpackage

// File: rtl/pp_stage_launcher.sv
// Drives one ap_ctrl_chain child: holds start until ready, acks done for one
// cycle and reports the completion to the bookkeeping logic in the parent.
module pp_stage_launcher
  import pingpong_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic launch_ok_i,
  input  logic ready_i,
  input  logic done_i,
  output logic start_o,
  output logic continue_o,
  output logic done_evt_o
);

  side_state_e state_q, state_d;

  // State register.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments for state keep every flop updating from
    // pre-edge values, independent of block ordering in the simulator.
    if (rst_i) state_q <= X_IDLE;
    else       state_q <= state_d;
  end

  // Next state: a single-stage child (ready together with done) never
  // enters X_BUSY.
  always_comb begin
    // NOTE: assigning a default first means no path leaves state_d unassigned,
    // so no latch is inferred.
    state_d = state_q;
    case (state_q)
      X_IDLE:  if (launch_ok_i && ready_i && !done_i) state_d = X_BUSY;
      X_BUSY:  if (done_i) state_d = X_IDLE;
      default: state_d = X_IDLE;
    endcase
  end

  // Outputs: done seen in X_IDLE without an accepted launch is not acked, and
  // nothing is driven while reset is asserted.
  always_comb begin
    start_o    = 1'b0;
    done_evt_o = 1'b0;
    if (!rst_i) begin
      case (state_q)
        X_IDLE: begin
          start_o    = launch_ok_i;
          done_evt_o = launch_ok_i && ready_i && done_i;
        end
        X_BUSY:  done_evt_o = done_i;
        default: ;
      endcase
    end
  end

  assign continue_o = done_evt_o;

endmodule

// File: rtl/pingpong_sched.sv
// Sequences a producer and a consumer stage over a two-bank ping-pong buffer.
// Full flags behave as a 2-entry FIFO: the producer stalls while both banks
// are full, the consumer stalls while its bank is empty. One top-level start
// runs NUM_FRAMES frames; 2**CNT_W must exceed NUM_FRAMES.
module pingpong_sched
  import pingpong_pkg::*;
#(
  parameter int NUM_FRAMES = 8,
  parameter int CNT_W      = 4
) (
  input  logic ap_clk,
  input  logic ap_rst,
  input  logic ap_start,
  output logic ap_done,
  input  logic ap_continue,
  output logic ap_idle,
  output logic ap_ready,
  output logic prod_ap_start,
  input  logic prod_ap_ready,
  input  logic prod_ap_done,
  output logic prod_ap_continue,
  output logic prod_bank,
  output logic cons_ap_start,
  input  logic cons_ap_ready,
  input  logic cons_ap_done,
  output logic cons_ap_continue,
  output logic cons_bank
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_FRAMES);

  top_state_e           state_q, state_d;
  logic [NUM_BANKS-1:0] full_q, full_d;
  logic                 prod_bank_q, prod_bank_d;
  logic                 cons_bank_q, cons_bank_d;
  logic [CNT_W-1:0]     prod_cnt_q, prod_cnt_d;
  logic [CNT_W-1:0]     cons_cnt_q, cons_cnt_d;
  logic                 run, prod_ok, cons_ok, prod_evt, cons_evt;

  // Top FSM state register.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Top FSM next state; ap_start outside S_IDLE has no effect.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ap_start) state_d = S_RUN;
      S_RUN:   if (cons_cnt_q == LAST_CNT) state_d = S_DONE;
      S_DONE:  if (ap_continue) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Top FSM outputs and launch permissions for each side.
  always_comb begin
    ap_idle  = (state_q == S_IDLE) && !ap_start;
    ap_ready = !ap_rst && (state_q == S_IDLE) && ap_start;
    ap_done  = !ap_rst && (state_q == S_DONE);
    run      = !ap_rst && (state_q == S_RUN);
    prod_ok  = run && (prod_cnt_q < LAST_CNT) && !full_q[prod_bank_q];
    cons_ok  = run && full_q[cons_bank_q];
  end

  pp_stage_launcher u_prod (
    .clk_i       (ap_clk),
    .rst_i       (ap_rst),
    .launch_ok_i (prod_ok),
    .ready_i     (prod_ap_ready),
    .done_i      (prod_ap_done),
    .start_o     (prod_ap_start),
    .continue_o  (prod_ap_continue),
    .done_evt_o  (prod_evt)
  );

  pp_stage_launcher u_cons (
    .clk_i       (ap_clk),
    .rst_i       (ap_rst),
    .launch_ok_i (cons_ok),
    .ready_i     (cons_ap_ready),
    .done_i      (cons_ap_done),
    .start_o     (cons_ap_start),
    .continue_o  (cons_ap_continue),
    .done_evt_o  (cons_evt)
  );

  // Bank bookkeeping: completions fill/free the current bank and toggle it;
  // simultaneous completions always target different banks.
  always_comb begin
    full_d      = full_q;
    prod_bank_d = prod_bank_q;
    cons_bank_d = cons_bank_q;
    prod_cnt_d  = prod_cnt_q;
    cons_cnt_d  = cons_cnt_q;
    if (ap_ready) begin
      prod_cnt_d = '0;
      cons_cnt_d = '0;
    end
    if (prod_evt) begin
      full_d[prod_bank_q] = 1'b1;
      prod_bank_d         = ~prod_bank_q;
      if (prod_cnt_q < LAST_CNT) prod_cnt_d = prod_cnt_q + CNT_W'(1);
    end
    if (cons_evt) begin
      full_d[cons_bank_q] = 1'b0;
      cons_bank_d         = ~cons_bank_q;
      if (cons_cnt_q < LAST_CNT) cons_cnt_d = cons_cnt_q + CNT_W'(1);
    end
  end

  // Bookkeeping registers.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      full_q      <= '0;
      prod_bank_q <= 1'b0;
      cons_bank_q <= 1'b0;
      prod_cnt_q  <= '0;
      cons_cnt_q  <= '0;
    end else begin
      full_q      <= full_d;
      prod_bank_q <= prod_bank_d;
      cons_bank_q <= cons_bank_d;
      prod_cnt_q  <= prod_cnt_d;
      cons_cnt_q  <= cons_cnt_d;
    end
  end

  assign prod_bank = prod_bank_q;
  assign cons_bank = cons_bank_q;

endmodule

// File: tb/tb_pingpong_sched.sv
// Scoreboard bench for pingpong_sched with behavioural producer/consumer
// children. Expected bank sequences are queued when a run is started and
// popped by the monitor at every child acknowledge.
module tb_pingpong_sched;

  localparam int NF = 4;
  localparam int CW = 3;

  logic ap_clk = 1'b0;
  logic ap_rst, ap_start, ap_continue;
  logic ap_done, ap_idle, ap_ready;
  logic prod_ap_start, prod_ap_ready, prod_ap_done, prod_ap_continue, prod_bank;
  logic cons_ap_start, cons_ap_ready, cons_ap_done, cons_ap_continue, cons_bank;

  int n_checks = 0;
  int n_errors = 0;
  int q_prod[$];
  int q_cons[$];

  logic p_rwd, c_rwd;
  int   p_lat, c_lat;

  always #5 ap_clk = ~ap_clk;

  pingpong_sched #(.NUM_FRAMES(NF), .CNT_W(CW)) dut (
    .ap_clk           (ap_clk),
    .ap_rst           (ap_rst),
    .ap_start         (ap_start),
    .ap_done          (ap_done),
    .ap_continue      (ap_continue),
    .ap_idle          (ap_idle),
    .ap_ready         (ap_ready),
    .prod_ap_start    (prod_ap_start),
    .prod_ap_ready    (prod_ap_ready),
    .prod_ap_done     (prod_ap_done),
    .prod_ap_continue (prod_ap_continue),
    .prod_bank        (prod_bank),
    .cons_ap_start    (cons_ap_start),
    .cons_ap_ready    (cons_ap_ready),
    .cons_ap_done     (cons_ap_done),
    .cons_ap_continue (cons_ap_continue),
    .cons_bank        (cons_bank)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle of a child model. rwd=1: ready and done rise together after
  // lat cycles. rwd=0: ready pulses on the first start cycle, done after lat.
  // done is held until the cycle the scheduler acks it.
  task automatic child_step(input logic rst_s, input logic st, input logic ct,
                            input logic rwd, input int lat,
                            inout logic busy, inout int cnt,
                            inout logic rdy, inout logic dn);
    if (rst_s) begin
      busy = 1'b0; cnt = 0; rdy = 1'b0; dn = 1'b0;
    end else if (dn && ct) begin
      busy = 1'b0; rdy = 1'b0; dn = 1'b0;
    end else begin
      if (!rwd) rdy = 1'b0;
      if (!busy && st) begin
        busy = 1'b1;
        cnt  = lat;
        if (!rwd) rdy = 1'b1;
      end else if (busy && !dn) begin
        if (cnt > 1) cnt--;
        else begin
          dn = 1'b1;
          if (rwd) rdy = 1'b1;
        end
      end
    end
  endtask

  // Children drive on the falling edge and sample what the rising edge sees.
  initial begin : prod_child
    logic busy, st, ct, rs, rdy, dn;
    int   cnt;
    busy = 0; st = 0; ct = 0; rs = 0; rdy = 0; dn = 0; cnt = 0;
    prod_ap_ready = 0; prod_ap_done = 0;
    forever begin
      @(negedge ap_clk);
      child_step(rs, st, ct, p_rwd, p_lat, busy, cnt, rdy, dn);
      prod_ap_ready = rdy;
      prod_ap_done  = dn;
      #1;
      rs = ap_rst; st = prod_ap_start; ct = prod_ap_continue;
    end
  end

  initial begin : cons_child
    logic busy, st, ct, rs, rdy, dn;
    int   cnt;
    busy = 0; st = 0; ct = 0; rs = 0; rdy = 0; dn = 0; cnt = 0;
    cons_ap_ready = 0; cons_ap_done = 0;
    forever begin
      @(negedge ap_clk);
      child_step(rs, st, ct, c_rwd, c_lat, busy, cnt, rdy, dn);
      cons_ap_ready = rdy;
      cons_ap_done  = dn;
      #1;
      rs = ap_rst; st = cons_ap_start; ct = cons_ap_continue;
    end
  end

  // Monitor: every acknowledge must match the next queued bank; ap_done must
  // only rise once every queued frame has completed.
  initial begin : monitor
    logic done_prev;
    done_prev = 1'b0;
    forever begin
      @(negedge ap_clk);
      #1;
      if (prod_ap_continue) begin
        check("prod_ack_with_done", prod_ap_done, 1);
        check("prod_evt_expected", int'(q_prod.size() != 0), 1);
        if (q_prod.size() != 0) check("prod_bank", prod_bank, q_prod.pop_front());
      end
      if (cons_ap_continue) begin
        check("cons_ack_with_done", cons_ap_done, 1);
        check("cons_evt_expected", int'(q_cons.size() != 0), 1);
        if (q_cons.size() != 0) check("cons_bank", cons_bank, q_cons.pop_front());
      end
      if (ap_done && !done_prev) begin
        check("done_prod_drained", q_prod.size(), 0);
        check("done_cons_drained", q_cons.size(), 0);
      end
      done_prev = ap_done;
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge ap_clk);
    #1;
  endtask

  task automatic set_children(input logic prwd, input int plat,
                              input logic crwd, input int clat);
    p_rwd = prwd; p_lat = plat; c_rwd = crwd; c_lat = clat;
  endtask

  task automatic start_run();
    for (int i = 0; i < NF; i++) begin
      q_prod.push_back(i % 2);
      q_cons.push_back(i % 2);
    end
    @(negedge ap_clk); ap_start = 1'b1; #1;
    check("ap_ready_on_accept", ap_ready, 1);
    check("ap_idle_low_on_start", ap_idle, 0);
    @(negedge ap_clk); ap_start = 1'b0; #1;
    check("ap_ready_one_cycle", ap_ready, 0);
  endtask

  // Wait for ap_done, hold it for `hold` cycles (with a stray ap_start),
  // then acknowledge and confirm the return to idle.
  task automatic finish_run(input int hold);
    int i;
    i = 0;
    while (!ap_done && i < 3000) begin tick(); i++; end
    check("ap_done_reached", ap_done, 1);
    for (int k = 0; k < hold; k++) begin
      @(negedge ap_clk); ap_start = (k == 3); #1;
      check("done_held", ap_done, 1);
      check("no_child_start_in_done", prod_ap_start | cons_ap_start, 0);
      check("no_ready_in_done", ap_ready, 0);
    end
    @(negedge ap_clk); ap_start = 1'b0; ap_continue = 1'b1; #1;
    check("done_in_continue_cycle", ap_done, 1);
    @(negedge ap_clk); ap_continue = 1'b0; #1;
    check("done_cleared", ap_done, 0);
    check("idle_after_continue", ap_idle, 1);
  endtask

  initial begin : stimulus
    int i, viol;
    ap_rst = 1'b1; ap_start = 1'b0; ap_continue = 1'b0;
    set_children(1'b1, 4, 1'b1, 4);

    // Reset state.
    repeat (2) @(negedge ap_clk);
    #1;
    check("rst_idle", ap_idle, 1);
    check("rst_done", ap_done, 0);
    check("rst_ready", ap_ready, 0);
    check("rst_starts", prod_ap_start | cons_ap_start, 0);
    check("rst_continues", prod_ap_continue | cons_ap_continue, 0);
    check("rst_banks", prod_bank | cons_bank, 0);
    check("rst_full", dut.full_q, 0);
    @(negedge ap_clk); ap_start = 1'b1; #1;
    check("rst_idle_follows_start", ap_idle, 0);
    check("rst_no_ready", ap_ready, 0);
    @(negedge ap_clk); ap_start = 1'b0; ap_rst = 1'b0; #1;
    check("idle_after_reset", ap_idle, 1);

    // 1 + 6: single-stage children, then ap_done held for 10 cycles.
    start_run();
    finish_run(10);

    // 2: consumer stalled; producer fills both banks and waits.
    set_children(1'b1, 2, 1'b0, 50);
    start_run();
    i = 0;
    while (dut.full_q != 2'b11 && i < 500) begin tick(); i++; end
    check("s2_both_full", dut.full_q, 3);
    viol = 0; i = 0;
    while (!cons_ap_continue && i < 500) begin
      if (prod_ap_start) viol++;
      tick(); i++;
    end
    check("s2_prod_stalled", viol, 0);
    check("s2_cons_completed", cons_ap_continue, 1);
    tick();
    check("s2_bank0_freed", dut.full_q, 2);
    check("s2_prod_relaunch", prod_ap_start, 1);
    check("s2_prod_relaunch_bank", prod_bank, 0);
    finish_run(0);

    // 3: slow producer; consumer waits for the first filled bank.
    set_children(1'b1, 20, 1'b1, 2);
    start_run();
    viol = 0; i = 0;
    while (!prod_ap_continue && i < 200) begin
      if (cons_ap_start) viol++;
      tick(); i++;
    end
    check("s3_cons_held_while_empty", viol, 0);
    check("s3_prod_completed", prod_ap_continue, 1);
    check("s3_full_empty", dut.full_q, 0);
    tick();
    check("s3_cons_launch", cons_ap_start, 1);
    check("s3_cons_bank", cons_bank, 0);
    finish_run(0);

    // 4: simultaneous completion, producer on bank 1, consumer on bank 0.
    set_children(1'b1, 4, 1'b1, 4);
    start_run();
    i = 0;
    while (!(prod_ap_continue && cons_ap_continue) && i < 200) begin tick(); i++; end
    check("s4_coincident", prod_ap_continue & cons_ap_continue, 1);
    check("s4_prod_bank_before", prod_bank, 1);
    check("s4_cons_bank_before", cons_bank, 0);
    tick();
    check("s4_full", dut.full_q, 2);
    check("s4_prod_bank_after", prod_bank, 0);
    check("s4_cons_bank_after", cons_bank, 1);
    finish_run(0);

    // 5: reset mid-run with full=01, then a fresh run from bank 0.
    set_children(1'b1, 4, 1'b0, 50);
    start_run();
    i = 0;
    while (dut.full_q != 2'b01 && i < 200) begin tick(); i++; end
    check("s5_full_01", dut.full_q, 1);
    @(negedge ap_clk); ap_rst = 1'b1; #1;
    check("s5_no_ack_in_reset", prod_ap_continue | cons_ap_continue, 0);
    @(negedge ap_clk); ap_rst = 1'b0; #1;
    check("s5_starts_cleared", prod_ap_start | cons_ap_start, 0);
    check("s5_full_cleared", dut.full_q, 0);
    check("s5_idle", ap_idle, 1);
    check("s5_banks_cleared", prod_bank | cons_bank, 0);
    check("s5_done_low", ap_done, 0);
    q_prod.delete();
    q_cons.delete();
    set_children(1'b1, 3, 1'b1, 3);
    start_run();
    finish_run(0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
